// File: rtl/nrzi_stuff_enc.sv
// nrzi_stuff_enc: USB-style NRZI line encoder with a ready/valid input and a return to IDLE_LEVEL between packets.
// Define NRZI_STUFF_EN to insert a 0 after STUFF_LEN consecutive ones; otherwise it is a framed 1-cycle NRZI encoder.
module nrzi_stuff_enc #(
  parameter int unsigned STUFF_LEN  = 6,
  parameter logic        IDLE_LEVEL = 1'b1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_line,
  output logic [CNT_W-1:0] stuff_cnt
);

  if (STUFF_LEN < 1 || STUFF_LEN > 15) begin : g_bad_stuff_len
    $error("nrzi_stuff_enc: STUFF_LEN must be in 1..15");
  end

`ifdef NRZI_STUFF_EN
  typedef enum logic [1:0] {IDLE, RUN, STUFF} state_t;
`else
  typedef enum logic {IDLE, RUN} state_t;
`endif

  state_t state_q, state_d;
  logic   accept;
  logic   emit;
  logic   emit_bit;
  logic   base_level;
  logic   line_d;

`ifdef NRZI_STUFF_EN
  localparam logic [3:0] STUFF_LEN_W = 4'(STUFF_LEN);

  logic [3:0]       ones_q, ones_d, ones_inc;
  logic             last_q;
  logic [CNT_W-1:0] stuff_cnt_q;

  assign in_ready  = (state_q != STUFF);
  assign stuff_cnt = stuff_cnt_q;
  // A packet's first beat counts from zero, whatever run of ones ended the previous packet.
  assign ones_inc  = ((state_q == IDLE) ? 4'd0 : ones_q) + 4'd1;
`else
  assign in_ready  = 1'b1;
  assign stuff_cnt = '0;
`endif

  assign accept     = in_valid & in_ready;
  assign base_level = (state_q == IDLE) ? IDLE_LEVEL : out_line;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d  = state_q;
    emit     = 1'b0;
    emit_bit = 1'b1;
`ifdef NRZI_STUFF_EN
    ones_d   = ones_q;
    if (state_q == STUFF) begin
      emit     = 1'b1;
      emit_bit = 1'b0;
      ones_d   = '0;
      state_d  = last_q ? IDLE : RUN;
    end else
`endif
    if (accept) begin
      emit     = 1'b1;
      emit_bit = in_bit;
      state_d  = in_last ? IDLE : RUN;
`ifdef NRZI_STUFF_EN
      ones_d = in_bit ? ones_inc : 4'd0;
      if (in_bit && (ones_inc == STUFF_LEN_W)) begin
        ones_d  = ones_inc;
        state_d = STUFF;
      end
`endif
    end
  end

  // A 0 toggles the line, a 1 holds it; with nothing to send the line holds mid-packet and idles otherwise.
  always_comb begin
    if (emit) begin
      line_d = emit_bit ? base_level : ~base_level;
    end else if (state_d == IDLE) begin
      line_d = IDLE_LEVEL;
    end else begin
      line_d = out_line;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is assigned with <= so every register samples the pre-edge values.
    if (rst) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      out_line  <= IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      out_valid <= emit;
      out_line  <= line_d;
    end
  end

`ifdef NRZI_STUFF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q      <= '0;
      last_q      <= 1'b0;
      stuff_cnt_q <= '0;
    end else begin
      ones_q <= ones_d;
      if (accept) begin
        last_q <= in_last;
      end
      if (accept && state_q == IDLE) begin
        stuff_cnt_q <= '0;
      end else if (state_q == STUFF && stuff_cnt_q != '1) begin
        stuff_cnt_q <= stuff_cnt_q + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_nrzi_stuff_enc.sv
// Testbench for nrzi_stuff_enc: directed cycle tables for the framing/stuffing corners, then random
// packets checked against a bit-stream model built from the NRZI and stuffing rules.
module tb_nrzi_stuff_enc;

  localparam int unsigned STUFF_LEN  = 6;
  localparam logic        IDLE_LEVEL = 1'b1;
  localparam int unsigned CNT_W      = 8;
`ifdef NRZI_STUFF_EN
  localparam bit STUFF_EN = 1'b1;
`else
  localparam bit STUFF_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_bit;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_line;
  logic [CNT_W-1:0] stuff_cnt;

  int n_vec = 0;
  int n_err = 0;

  nrzi_stuff_enc #(
    .STUFF_LEN (STUFF_LEN),
    .IDLE_LEVEL(IDLE_LEVEL),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_line (out_line),
    .stuff_cnt(stuff_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_num(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One row per clock cycle: inputs driven for that cycle and the outputs seen during it.
  typedef struct {
    logic v, b, l;
    logic rdy, ov, ol;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic v, b, l, rdy, ov, ol);
    vec_t r;
    r = '{v: v, b: b, l: l, rdy: rdy, ov: ov, ol: ol};
    tbl.push_back(r);
  endtask

  task automatic run_table(input string name);
    foreach (tbl[i]) begin
      in_valid = tbl[i].v;
      in_bit   = tbl[i].b;
      in_last  = tbl[i].l;
      @(negedge clk);
      check_bit($sformatf("%s[%0d] in_ready", name, i), in_ready, tbl[i].rdy);
      check_bit($sformatf("%s[%0d] out_valid", name, i), out_valid, tbl[i].ov);
      check_bit($sformatf("%s[%0d] out_line", name, i), out_line, tbl[i].ol);
      @(posedge clk); #1;
    end
    tbl.delete();
  endtask

  task automatic fill_six_ones();
    for (int c = 0; c < 6; c++) add(1, 1, c == 5, 1, c != 0, 1);
    if (STUFF_EN) begin
      add(0, 1, 1, 0, 1, 1);
      add(0, 0, 0, 1, 1, 0);
      add(0, 0, 0, 1, 0, 1);
    end else begin
      add(0, 1, 1, 1, 1, 1);
      add(0, 0, 0, 1, 0, 1);
    end
  endtask

  // Random-phase model: expected line levels in emission order, plus ones/stuff bookkeeping.
  logic exp_q[$];
  bit   mon_en    = 1'b0;
  bit   stuff_due = 1'b0;
  int   ones      = 0;
  int   pkt_stuffs = 0;
  logic lvl       = IDLE_LEVEL;

  always @(negedge clk) begin
    if (mon_en && !rst && out_valid !== 1'b0) begin
      if (exp_q.size() == 0) check_bit("mon unexpected out_valid", out_valid, 1'b0);
      else                   check_bit("mon out_line", out_line, exp_q.pop_front());
    end
  end

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_bit   = 1'($urandom);
      in_last  = 1'($urandom);
      @(posedge clk); #1;
      stuff_due = 1'b0;
    end
  endtask

  task automatic send_beat(input logic b, input logic last, input bit first);
    logic r;
    logic exp_r;
    bit   accepted;
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = last;
    exp_r    = !stuff_due;
    accepted = 1'b0;
    for (int t = 0; t < 4 && !accepted; t++) begin
      @(negedge clk);
      check_bit("rand in_ready", in_ready, exp_r);
      r = in_ready;
      @(posedge clk); #1;
      stuff_due = 1'b0;
      exp_r     = 1'b1;
      accepted  = (r === 1'b1);
    end
    check_bit("rand beat accepted", accepted, 1'b1);
    if (first) begin
      lvl        = IDLE_LEVEL;
      ones       = 0;
      pkt_stuffs = 0;
    end
    if (!b) lvl = ~lvl;
    exp_q.push_back(lvl);
    ones = b ? ones + 1 : 0;
    if (STUFF_EN && ones == STUFF_LEN) begin
      ones = 0;
      lvl  = ~lvl;
      exp_q.push_back(lvl);
      stuff_due = 1'b1;
      pkt_stuffs++;
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    in_last  = 1'b0;
    #2;
    check_bit("reset out_line", out_line, IDLE_LEVEL);
    check_bit("reset out_valid", out_valid, 1'b0);
    check_bit("reset in_ready", in_ready, 1'b1);
    check_num("reset stuff_cnt", int'(stuff_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Bits 1,0,0,1 -> line 1,0,1,1 then idle.
    add(1, 1, 0, 1, 0, 1);
    add(1, 0, 0, 1, 1, 1);
    add(1, 0, 0, 1, 1, 0);
    add(1, 1, 1, 1, 1, 1);
    add(0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 1, 0, 1);
    run_table("bits1001");

    // Seven ones, last on the 7th; the 7th is held through the stuff cycle.
    if (STUFF_EN) begin
      for (int c = 0; c < 6; c++) add(1, 1, 0, 1, c != 0, 1);
      add(1, 1, 1, 0, 1, 1);
      add(1, 1, 1, 1, 1, 0);
      add(0, 0, 0, 1, 1, 0);
      add(0, 0, 0, 1, 0, 1);
    end else begin
      for (int c = 0; c < 7; c++) add(1, 1, c == 6, 1, c != 0, 1);
      add(0, 0, 0, 1, 1, 1);
      add(0, 0, 0, 1, 0, 1);
    end
    run_table("seven_ones");
    check_num("seven_ones stuff_cnt", int'(stuff_cnt), STUFF_EN ? 1 : 0);

    fill_six_ones();
    run_table("six_ones");
    check_num("six_ones stuff_cnt", int'(stuff_cnt), STUFF_EN ? 1 : 0);

    // 1,1,1,1,1,0,1,1,1 <3 bubbles with junk inputs> 1,1,1(last): one stuff after the 12th bit.
    add(1, 1, 0, 1, 0, 1);
    for (int c = 1; c < 5; c++) add(1, 1, 0, 1, 1, 1);
    add(1, 0, 0, 1, 1, 1);
    for (int c = 6; c < 9; c++) add(1, 1, 0, 1, 1, 0);
    add(0, 0, 1, 1, 1, 0);
    add(0, 0, 1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0);
    add(1, 1, 0, 1, 0, 0);
    add(1, 1, 0, 1, 1, 0);
    add(1, 1, 1, 1, 1, 0);
    add(0, 0, 0, !STUFF_EN, 1, 0);
    add(0, 0, 0, 1, STUFF_EN, 1);
    add(0, 0, 0, 1, 0, 1);
    run_table("bubbled_run");
    check_num("bubbled_run stuff_cnt", int'(stuff_cnt), STUFF_EN ? 1 : 0);

    // Mid-packet asynchronous reset, after a stuff has already been counted.
    in_valid = 1'b1;
    in_bit   = 1'b1;
    in_last  = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check_bit("pre_reset out_valid", out_valid, 1'b1);
    check_num("pre_reset stuff_cnt", int'(stuff_cnt), STUFF_EN ? 1 : 0);
    #3;
    rst = 1'b1;
    #1;
    check_bit("async_reset out_line", out_line, IDLE_LEVEL);
    check_bit("async_reset out_valid", out_valid, 1'b0);
    check_bit("async_reset in_ready", in_ready, 1'b1);
    check_num("async_reset stuff_cnt", int'(stuff_cnt), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b0;
    @(posedge clk); #1;
    fill_six_ones();
    run_table("after_reset");
    check_num("after_reset stuff_cnt", int'(stuff_cnt), STUFF_EN ? 1 : 0);

    // Random packets, back-to-back or separated by idle gaps, with bubbles inside packets.
    mon_en = 1'b1;
    for (int p = 0; p < 60; p++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int k = 0; k < len; k++) begin
        if (k > 0 && $urandom_range(0, 4) == 0) bubble($urandom_range(1, 3));
        send_beat(1'($urandom_range(0, 3) != 0), k == len - 1, k == 0);
      end
      if ($urandom_range(0, 1) == 1) begin
        bubble(2);
        @(negedge clk);
        check_bit("gap out_valid", out_valid, 1'b0);
        check_bit("gap out_line", out_line, IDLE_LEVEL);
        check_num("gap stuff_cnt", int'(stuff_cnt), pkt_stuffs);
        @(posedge clk); #1;
      end
    end
    bubble(4);
    mon_en = 1'b0;
    check_num("rand pending emissions", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
